mult_div_unit: RTL and testbench

- Parametrised multicycle multiply/divide unit for the multicycle CPU datapath. It adds the MULT and DIV capability the current datapath lacks.
- Operands come from register file outputs A and B. Results are held in internal HI/LO registers, which feed the MemToReg mux (MFHI/MFLO).
- The control unit launches an operation with a start pulse and waits for done. The ALU stays free while the operation runs.

---
 rtl/mult_div_unit_pkg.sv | 15 +
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit_div_step.sv | 23 ++
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared types and helpers for the multicycle multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} mdu_state_t;

  typedef enum logic {MDU_MULT = 1'b0, MDU_DIV = 1'b1} mdu_op_t;

  // Widest operand the helpers below can handle.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit side bus of the multiply/divide unit.
interface mult_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
);
  // start is a request honoured only while the unit is idle; done is a one-cycle
  // pulse and HI/LO/div_zero are final while it is high. There is no back-pressure.
  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on unsigned magnitudes.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           q_bit;

  // rem < dvs always, so the shifted remainder fits and a borrow marks failure.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], q_bit};
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  mult_div_unit_if.slave bus,
  output mdu_state_t  state
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH:0]   p_hi;
  logic [WIDTH-1:0] p_lo;
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return WIDTH'(cond_neg(MAX_W'(v), neg));
  endfunction

  always_comb begin
    m_ext     = {m_reg[WIDTH-1], m_reg};
    booth_sum = p_hi;
    case ({p_lo[0], q_m1})
      2'b01:   booth_sum = p_hi + m_ext;
      2'b10:   booth_sum = p_hi - m_ext;
      default: booth_sum = p_hi;
    endcase
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (p_hi[WIDTH-1:0]),
    .dvd      (p_lo),
    .dvs      (m_reg),
    .rem_next (rem_next),
    .dvd_next (dvd_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi_out   <= '0;
      bus.lo_out   <= '0;
      cnt          <= '0;
      p_hi         <= '0;
      p_lo         <= '0;
      q_m1         <= 1'b0;
      m_reg        <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy     <= 1'b1;
            bus.div_zero <= 1'b0;
            cnt          <= '0;
            p_hi         <= '0;
            q_m1         <= 1'b0;
            sign_q       <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            sign_r       <= bus.a_in[WIDTH-1];
            if (bus.op == MDU_MULT) begin
              p_lo  <= bus.a_in;
              m_reg <= bus.b_in;
              state <= MULT;
            end else begin
              p_lo  <= neg_w(bus.a_in, bus.a_in[WIDTH-1]);
              m_reg <= neg_w(bus.b_in, bus.b_in[WIDTH-1]);
              state <= DIV;
              // A zero divisor skips the iterations: one DIV cycle, then FINISH.
              if (bus.b_in == '0) begin
                bus.div_zero <= 1'b1;
                cnt          <= CNT_W'(WIDTH);
              end
            end
          end
        end
        MULT: begin
          if (cnt == CNT_W'(WIDTH)) begin
            bus.hi_out <= p_hi[WIDTH-1:0];
            bus.lo_out <= p_lo;
            bus.done   <= 1'b1;
            state      <= FINISH;
          end else begin
            p_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            p_lo <= {booth_sum[0], p_lo[WIDTH-1:1]};
            q_m1 <= p_lo[0];
            cnt  <= cnt + CNT_W'(1);
          end
        end
        DIV: begin
          if (cnt == CNT_W'(WIDTH)) begin
            if (!bus.div_zero) begin
              bus.hi_out <= neg_w(p_hi[WIDTH-1:0], sign_r);
              bus.lo_out <= neg_w(p_lo, sign_q);
            end
            bus.done <= 1'b1;
            state    <= FINISH;
          end else begin
            p_hi <= {1'b0, rem_next};
            p_lo <= dvd_next;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  mdu_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [2*W:0] exp_q[$];
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave),
    .state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: {div_zero, hi, lo}
  function automatic logic [2*W:0] model(input logic opc, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, p, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    if (!opc) begin
      p = x * y;
      return {1'b0, p[2*W-1:W], p[W-1:0]};
    end
    if (b == '0) return {1'b1, model_hi, model_lo};
    q = x / y;
    r = x % y;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      logic [2*W:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", bus.hi_out, bus.lo_out);
      end else begin
        e = exp_q.pop_front();
        if ({bus.div_zero, bus.hi_out, bus.lo_out} !== e) begin
          errors++;
          $display("FAIL result: got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                   bus.div_zero, bus.hi_out, bus.lo_out, e[2*W], e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  // driver
  task automatic run_op(input logic opc, input logic [W-1:0] a, input logic [W-1:0] b, input bit glitch);
    logic [2*W:0] e;
    int lat, exp_lat;
    bit busy_ok, seen;
    e = model(opc, a, b);
    exp_q.push_back(e);
    model_hi = e[2*W-1:W];
    model_lo = e[W-1:0];
    exp_lat = (opc && b == '0) ? 2 : W + 2;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = opc ? MDU_DIV : MDU_MULT;
    bus.a_in  = a;
    bus.b_in  = b;
    lat = 0; busy_ok = 1'b1; seen = 1'b0;
    while (lat < 200 && !seen) begin
      @(posedge clk); #1;
      lat++;
      bus.start = 1'b0;
      if (glitch && (lat == 5 || lat == 20)) begin
        bus.start = 1'b1;
        bus.op    = $urandom_range(0, 1) ? MDU_DIV : MDU_MULT;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) seen = 1'b1;
      if (lat == 1) chk("div_zero_on_accept", bus.div_zero, opc && b == '0);
    end
    bus.start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", lat, exp_lat);
    chk("busy_held", busy_ok, 1);
  endtask

  task automatic expect_quiet(input int n);
    int d = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.done) d++;
    end
    chk("no_extra_done", d, 0);
    chk("idle_state", dbg_state, IDLE);
    chk("idle_busy", bus.busy, 0);
  endtask

  task automatic reset_mid_div(input logic [W-1:0] a, input logic [W-1:0] b, input int at);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = MDU_DIV;
    bus.a_in  = a;
    bus.b_in  = b;
    repeat (at) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_hi = '0;
    model_lo = '0;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_hi", bus.hi_out, 0);
    chk("rst_mid_lo", bus.lo_out, 0);
    chk("rst_mid_state", dbg_state, IDLE);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return MIN_V;
      4:       return W'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_div_zero", bus.div_zero, 0);
    chk("reset_hi", bus.hi_out, 0);
    chk("reset_lo", bus.lo_out, 0);
    chk("reset_state", dbg_state, IDLE);

    run_op(1'b0, W'(7), W'(-3), 1'b0);
    run_op(1'b0, MIN_V, MIN_V, 1'b0);
    run_op(1'b0, '1, '1, 1'b0);
    run_op(1'b1, W'(-7), W'(2), 1'b0);
    run_op(1'b1, MIN_V, '1, 1'b0);
    chk("min_div_neg1_flag", bus.div_zero, 0);

    run_op(1'b0, 32'h1234_5678, 32'h0ABC_DEF1, 1'b0);
    run_op(1'b1, W'(5), '0, 1'b0);
    chk("div_zero_sticky", bus.div_zero, 1);
    chk("div_zero_hi_kept", bus.hi_out, model_hi);
    run_op(1'b0, W'(3), W'(4), 1'b0);
    chk("div_zero_cleared", bus.div_zero, 0);

    run_op(1'b0, 32'h0000_1234, 32'hFFFF_0F0F, 1'b1);
    expect_quiet(45);
    run_op(1'b1, W'(1000), W'(-33), 1'b0);
    run_op(1'b0, W'(-9), W'(11), 1'b0);

    reset_mid_div(32'h7FFF_FFFF, W'(3), 10);
    run_op(1'b1, W'(100), W'(7), 1'b0);
    chk("div_100_7_lo", bus.lo_out, W'(14));
    chk("div_100_7_hi", bus.hi_out, W'(2));

    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 1'b0);
    end
    expect_quiet(5);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
